camera_stream_gen: RTL and testbench
====================================

Name: camera_stream_gen

Overview:
Synthetic camera-side source for the edge-detection pipeline. It is the transmitter of the href/vsync/RGB565 stream that the Sobel processor receives. It produces frame timing (vsync pulse, back porch, active rows with horizontal blanking, front porch) at one pixel per clock. It fills the active pixels with a selectable test pattern. It stands in for the OV camera in simulation and in on-board bring-up on Tang Nano 4K.

Parameters:
IMG_WIDTH, 640, active pixels per row (≥16, multiple of 8)
IMG_HEIGHT, 480, active rows per frame (≥2)
H_BLANK, 160, blank cycles after each active row (≥1)
VSYNC_LINES, 3, line periods with vsync high
V_BACK_LINES, 17, line periods between vsync fall and first active row
V_FRONT_LINES, 10, line periods after last row before frame end
BAR_STEP, 4, moving-bar width and per-frame shift in pixels

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  run frames; sampled in IDLE and at frame end
pattern_sel  in  2  00 colour bars, 01 gray ramp, 10 checkerboard, 11 moving bar
href  out  1  high during active pixels of a row
vsync  out  1  high during VSYNC period
pixel_out  out  16  RGB565 pixel, valid when href=1, else 16'h0000
frame_done  out  1  one-cycle pulse at end of each frame
frame_count  out  8  completed frames, wraps 255→0
busy  out  1  high in every state except IDLE

Behaviour:
- One clock; reset is synchronous and active-high on rst. All outputs are registered.
- Reset state: href=0, vsync=0, pixel_out=0, frame_done=0, frame_count=0, busy=0. FSM=IDLE. Bar position xpos=0.
- LINE_PERIOD = IMG_WIDTH + H_BLANK.
- FSM states: IDLE → VSYNC → V_BACK → ACTIVE ⇄ H_BLNK → V_FRONT → (VSYNC | IDLE).
- IDLE: if enable=1 at an edge, the next cycle shows vsync=1 and busy=1. At that same transition, pattern_sel is latched; it is held for the whole frame.
- VSYNC: vsync=1 for VSYNC_LINES*LINE_PERIOD cycles.
- V_BACK: lasts V_BACK_LINES*LINE_PERIOD cycles.
- ACTIVE: href=1 for exactly IMG_WIDTH consecutive cycles. col counts 0..IMG_WIDTH-1. pixel_out is the pattern for (col,row) in the same cycle.
- H_BLNK: H_BLANK cycles with href=0. After the blank, row increments and the FSM returns to ACTIVE. After row IMG_HEIGHT-1, the FSM goes to V_FRONT instead.
- V_FRONT: lasts V_FRONT_LINES*LINE_PERIOD cycles.
- At the V_FRONT exit edge, three things happen together:
  - frame_done=1 for one cycle;
  - frame_count increments;
  - xpos += BAR_STEP, or becomes 0 if xpos+BAR_STEP ≥ IMG_WIDTH.
- V_FRONT exit, next state:
  - enable=1: VSYNC begins in the same cycle as frame_done.
  - enable=0: IDLE, with busy=0 in that cycle.
- Frame period is (VSYNC_LINES + V_BACK_LINES + IMG_HEIGHT + V_FRONT_LINES) * LINE_PERIOD cycles, with no gaps in continuous mode.
- Deasserting enable mid-frame has no effect until the frame finishes.
- Changing pattern_sel mid-frame has no effect until the next frame.
- rst mid-frame: all outputs return to reset values on the next edge, including frame_count and xpos.
- Patterns, where g is an 8-bit gray level and gray(g) = {g[7:3], g[7:2], g[7:3]}:
  - 00 colour bars: bar = min(col/(IMG_WIDTH/8), 7). Colours by bar: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Implement with a bar counter, not a divider.
  - 01 gray ramp: gray(col[7:0]).
  - 10 checkerboard: FFFF if col[3]^row[3], else 0000.
  - 11 moving bar: FFFF if xpos ≤ col < xpos+BAR_STEP, else 0000.

Decomposition:
- Package camera_stream_pkg holds:
  - FSM state encoding;
  - pattern codes PAT_BARS/PAT_RAMP/PAT_CHECK/PAT_MOVE;
  - the eight RGB565 bar colour constants.
- Sub-module stream_pattern_gen is a natural split. It is combinational: inputs pattern, col, row, bar index, xpos; output rgb565. The top registers its output together with href.

Test Plan:
(All scenarios use IMG_WIDTH=16, IMG_HEIGHT=4, H_BLANK=4, VSYNC_LINES=1, V_BACK_LINES=1, V_FRONT_LINES=1, BAR_STEP=4. LINE_PERIOD=20, frame=140 cycles.)
- Reset: assert rst 3 cycles with enable=1 → href=vsync=frame_done=busy=0, pixel_out=0000, frame_count=0.
- Timing: enable=1 from IDLE → vsync high 20 cycles. First href rise 40 cycles after vsync rise. Four href pulses of 16 cycles, 20 apart. frame_done 140 cycles after vsync rise, coincident with the next vsync rise.
- Colour bars: row 0 → cols 0-1 FFFF, 2-3 FFE0, 4-5 07FF, … 14-15 0000. pixel_out=0000 while href=0.
- Ramp/checker: pattern 01, col 5 → 0020, col 15 → 0861. Pattern 10 → row0 col0 0000, row0 col8 FFFF.
- Moving bar: pattern 11 over 5 frames → white columns 0-3, 4-7, 8-11, 12-15, 0-3 (wrap). frame_count 0→5.
- Stop/mid-frame events: drop enable at row 2 → frame completes, frame_done pulses, busy=0 and FSM in IDLE next. Change pattern_sel mid-frame → unchanged until next frame. rst mid-ACTIVE → outputs 0 on the next edge.

Source files
------------

// File: rtl/camera_stream_pkg.sv
// camera_stream_pkg
// Shared definitions for the synthetic camera stream source: FSM state
// encoding, test-pattern select codes, the eight RGB565 colour-bar colours
// and small helpers that map a bar index or an 8-bit gray level to RGB565.
package camera_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VSYNC   = 3'd1,
    ST_V_BACK  = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_H_BLNK  = 3'd4,
    ST_V_FRONT = 3'd5
  } cam_state_e;

  localparam logic [1:0] PAT_BARS  = 2'b00;
  localparam logic [1:0] PAT_RAMP  = 2'b01;
  localparam logic [1:0] PAT_CHECK = 2'b10;
  localparam logic [1:0] PAT_MOVE  = 2'b11;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // Colour of bar 0..7, left to right.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

  // 8-bit gray level expanded to RGB565 (top 5/6/5 bits of the level).
  function automatic logic [15:0] gray565(input logic [7:0] g);
    return {g[7:3], g[7:2], g[7:3]};
  endfunction

endpackage

// File: rtl/stream_pattern_gen.sv
// stream_pattern_gen
// Combinational test-pattern generator for one pixel.
// Ports:
//   pattern  in  2   pattern select (bars / gray ramp / checker / moving bar)
//   col      in  16  column of the pixel within the active row
//   row_b3   in  1   bit 3 of the row index (all the checkerboard needs)
//   bar      in  3   colour-bar index for this column, kept by the caller
//   xpos     in  16  left edge of the moving bar for the current frame
//   rgb565   out 16  pixel colour
module stream_pattern_gen
  import camera_stream_pkg::*;
#(
  parameter int BAR_STEP = 4
) (
  input  logic [1:0]  pattern,
  input  logic [15:0] col,
  input  logic        row_b3,
  input  logic [2:0]  bar,
  input  logic [15:0] xpos,
  output logic [15:0] rgb565
);

  logic [16:0] bar_end;
  logic        in_bar;

  always_comb begin
    // One extra bit so xpos+BAR_STEP cannot wrap near the right edge.
    bar_end = {1'b0, xpos} + 17'(BAR_STEP);
    in_bar  = (col >= xpos) && ({1'b0, col} < bar_end);
    case (pattern)
      PAT_BARS:  rgb565 = bar_color(bar);
      PAT_RAMP:  rgb565 = gray565(col[7:0]);
      PAT_CHECK: rgb565 = (col[3] ^ row_b3) ? RGB_WHITE : RGB_BLACK;
      default:   rgb565 = in_bar ? RGB_WHITE : RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/camera_stream_gen.sv
// camera_stream_gen
// Synthetic camera source producing href/vsync/RGB565 frame timing at one
// pixel per clock: vsync pulse, back porch, active rows separated by
// horizontal blanking, front porch. Active pixels carry a test pattern
// latched at the start of each frame.
// Ports:
//   clk          in  1   system clock
//   rst          in  1   synchronous active-high reset
//   enable       in  1   run frames; looked at only in IDLE and at frame end
//   pattern_sel  in  2   test pattern for the next frame
//   href         out 1   high during active pixels
//   vsync        out 1   high during the vsync period
//   pixel_out    out 16  RGB565 pixel, zero whenever href is low
//   frame_done   out 1   one-cycle pulse as each frame ends
//   frame_count  out 8   completed frames, wrapping
//   busy         out 1   high whenever not idle
module camera_stream_gen
  import camera_stream_pkg::*;
#(
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480,
  parameter int H_BLANK       = 160,
  parameter int VSYNC_LINES   = 3,
  parameter int V_BACK_LINES  = 17,
  parameter int V_FRONT_LINES = 10,
  parameter int BAR_STEP      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        href,
  output logic        vsync,
  output logic [15:0] pixel_out,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        busy
);

  localparam int LINE_PERIOD = IMG_WIDTH + H_BLANK;

  localparam logic [23:0] VS_LAST  = 24'(VSYNC_LINES * LINE_PERIOD - 1);
  localparam logic [23:0] VB_LAST  = 24'(V_BACK_LINES * LINE_PERIOD - 1);
  localparam logic [23:0] VF_LAST  = 24'(V_FRONT_LINES * LINE_PERIOD - 1);
  localparam logic [23:0] HB_LAST  = 24'(H_BLANK - 1);
  localparam logic [15:0] COL_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMG_HEIGHT - 1);
  localparam logic [15:0] BARW_LAST = 16'(IMG_WIDTH / 8 - 1);

  cam_state_e  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic [2:0]  bar_q, bar_d;
  logic [15:0] bar_cnt_q, bar_cnt_d;
  logic [15:0] xpos_q, xpos_d;
  logic [1:0]  pat_q, pat_d;
  logic        href_q, href_d;
  logic        vsync_q, vsync_d;
  logic [15:0] pixel_q, pixel_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic        busy_q, busy_d;
  logic [16:0] xpos_sum;
  logic [15:0] pat_rgb;

  // Pattern is evaluated on the next-cycle coordinates so the registered
  // pixel lines up with the registered href.
  stream_pattern_gen #(
    .BAR_STEP (BAR_STEP)
  ) u_pattern (
    .pattern (pat_d),
    .col     (col_d),
    .row_b3  (row_d[3]),
    .bar     (bar_d),
    .xpos    (xpos_q),
    .rgb565  (pat_rgb)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    col_d         = col_q;
    row_d         = row_q;
    bar_d         = bar_q;
    bar_cnt_d     = bar_cnt_q;
    xpos_d        = xpos_q;
    pat_d         = pat_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    xpos_sum      = {1'b0, xpos_q} + 17'(BAR_STEP);

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_VSYNC;
          cnt_d   = '0;
          pat_d   = pattern_sel;
        end
      end
      ST_VSYNC: begin
        if (cnt_q == VS_LAST) begin
          state_d = ST_V_BACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_V_BACK: begin
        if (cnt_q == VB_LAST) begin
          state_d   = ST_ACTIVE;
          col_d     = '0;
          row_d     = '0;
          bar_d     = '0;
          bar_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_ACTIVE: begin
        if (col_q == COL_LAST) begin
          state_d = ST_H_BLNK;
          cnt_d   = '0;
        end else begin
          col_d = col_q + 16'd1;
          // Bar index advances every IMG_WIDTH/8 columns instead of dividing.
          if (bar_cnt_q == BARW_LAST) begin
            bar_cnt_d = '0;
            if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
          end else begin
            bar_cnt_d = bar_cnt_q + 16'd1;
          end
        end
      end
      ST_H_BLNK: begin
        if (cnt_q == HB_LAST) begin
          if (row_q == ROW_LAST) begin
            state_d = ST_V_FRONT;
            cnt_d   = '0;
          end else begin
            state_d   = ST_ACTIVE;
            row_d     = row_q + 16'd1;
            col_d     = '0;
            bar_d     = '0;
            bar_cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_V_FRONT: begin
        if (cnt_q == VF_LAST) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          xpos_d        = (xpos_sum >= 17'(IMG_WIDTH)) ? 16'd0 : xpos_sum[15:0];
          cnt_d         = '0;
          if (enable) begin
            state_d = ST_VSYNC;
            pat_d   = pattern_sel;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    href_d  = (state_d == ST_ACTIVE);
    vsync_d = (state_d == ST_VSYNC);
    busy_d  = (state_d != ST_IDLE);
    pixel_d = href_d ? pat_rgb : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      bar_q         <= '0;
      bar_cnt_q     <= '0;
      xpos_q        <= '0;
      pat_q         <= PAT_BARS;
      href_q        <= 1'b0;
      vsync_q       <= 1'b0;
      pixel_q       <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      bar_q         <= bar_d;
      bar_cnt_q     <= bar_cnt_d;
      xpos_q        <= xpos_d;
      pat_q         <= pat_d;
      href_q        <= href_d;
      vsync_q       <= vsync_d;
      pixel_q       <= pixel_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
    end
  end

  assign href        = href_q;
  assign vsync       = vsync_q;
  assign pixel_out   = pixel_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_camera_stream_gen.sv
// tb_camera_stream_gen
// Directed bench for camera_stream_gen with a 16x4 image, 4-cycle blanking
// and one line each of vsync, back porch and front porch (140-cycle frames).
module tb_camera_stream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        href;
  logic        vsync;
  logic [15:0] pixel_out;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [15:0] row0_px [16];

  always #5 clk = ~clk;

  camera_stream_gen #(
    .IMG_WIDTH     (16),
    .IMG_HEIGHT    (4),
    .H_BLANK       (4),
    .VSYNC_LINES   (1),
    .V_BACK_LINES  (1),
    .V_FRONT_LINES (1),
    .BAR_STEP      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .href        (href),
    .vsync       (vsync),
    .pixel_out   (pixel_out),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bar_ref(input int idx);
    case (idx)
      0:       return 16'hFFFF;
      1:       return 16'hFFE0;
      2:       return 16'h07FF;
      3:       return 16'h07E0;
      4:       return 16'hF81F;
      5:       return 16'hF800;
      6:       return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] exp_px(input logic [1:0] p, input int c, input int r, input int xp);
    logic [7:0] g;
    g = 8'(c);
    case (p)
      2'b00:   return bar_ref(c / 2);
      2'b01:   return {g[7:3], g[7:2], g[7:3]};
      2'b10:   return ((((c >> 3) ^ (r >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return (c >= xp && c < xp + 4) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Called on the negedge where vsync has just risen (t=0); returns on the
  // negedge 140 cycles later, where frame_done should be high.
  task automatic run_frame(input logic [1:0] pat, input int xp, input int cnt_exp,
                           input logic [1:0] mid_pat, input bit drop_en);
    int e_vs = 0;
    int e_hr = 0;
    int e_px = 0;
    int e_bz = 0;
    int e_fd = 0;
    for (int t = 0; t < 140; t++) begin
      int ln;
      int c;
      int r;
      logic act;
      logic [15:0] pe;
      ln  = t - 40;
      act = (t >= 40) && (t < 120) && ((ln % 20) < 16);
      c   = act ? ln % 20 : 0;
      r   = act ? ln / 20 : 0;
      pe  = act ? exp_px(pat, c, r, xp) : 16'h0000;
      if (vsync !== (t < 20)) e_vs++;
      if (href !== act) e_hr++;
      if (pixel_out !== pe) e_px++;
      if (busy !== 1'b1) e_bz++;
      if (t > 0 && frame_done !== 1'b0) e_fd++;
      if (act && r == 0) row0_px[c] = pixel_out;
      if (t == 70) pattern_sel = mid_pat;
      if (t == 80 && drop_en) enable = 1'b0;
      @(negedge clk);
    end
    chk("vsync_bad_cycles", e_vs, 0);
    chk("href_bad_cycles", e_hr, 0);
    chk("pixel_bad_cycles", e_px, 0);
    chk("busy_bad_cycles", e_bz, 0);
    chk("frame_done_early", e_fd, 0);
    chk("frame_done_end", 32'(frame_done), 1);
    chk("frame_count_end", 32'(frame_count), cnt_exp);
    chk("vsync_after_end", 32'(vsync), drop_en ? 0 : 1);
    chk("busy_after_end", 32'(busy), drop_en ? 0 : 1);
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b1;
    pattern_sel = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_href", 32'(href), 0);
    chk("rst_vsync", 32'(vsync), 0);
    chk("rst_pixel", 32'(pixel_out), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_busy", 32'(busy), 0);

    rst    = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_vsync", 32'(vsync), 0);

    // Frame 1: colour bars; pattern_sel moved to ramp mid-frame.
    enable = 1'b1;
    @(negedge clk);
    run_frame(2'b00, 0, 1, 2'b01, 1'b0);
    chk("bar_c0", 32'(row0_px[0]), 32'hFFFF);
    chk("bar_c1", 32'(row0_px[1]), 32'hFFFF);
    chk("bar_c2", 32'(row0_px[2]), 32'hFFE0);
    chk("bar_c3", 32'(row0_px[3]), 32'hFFE0);
    chk("bar_c4", 32'(row0_px[4]), 32'h07FF);
    chk("bar_c7", 32'(row0_px[7]), 32'h07E0);
    chk("bar_c8", 32'(row0_px[8]), 32'hF81F);
    chk("bar_c10", 32'(row0_px[10]), 32'hF800);
    chk("bar_c12", 32'(row0_px[12]), 32'h001F);
    chk("bar_c15", 32'(row0_px[15]), 32'h0000);

    // Frame 2: gray ramp; pattern_sel moved to checker mid-frame.
    run_frame(2'b01, 4, 2, 2'b10, 1'b0);
    chk("ramp_c0", 32'(row0_px[0]), 32'h0000);
    chk("ramp_c5", 32'(row0_px[5]), 32'h0020);
    chk("ramp_c15", 32'(row0_px[15]), 32'h0861);

    // Frame 3: checkerboard; enable dropped at row 2.
    run_frame(2'b10, 8, 3, 2'b11, 1'b1);
    chk("check_c0", 32'(row0_px[0]), 32'h0000);
    chk("check_c7", 32'(row0_px[7]), 32'h0000);
    chk("check_c8", 32'(row0_px[8]), 32'hFFFF);
    @(negedge clk);
    chk("stop_frame_done_low", 32'(frame_done), 0);
    chk("stop_busy_low", 32'(busy), 0);
    chk("stop_vsync_low", 32'(vsync), 0);

    // Reset in the middle of an active row.
    pattern_sel = 2'b00;
    enable      = 1'b1;
    @(negedge clk);
    chk("midrst_vsync_start", 32'(vsync), 1);
    repeat (45) @(negedge clk);
    chk("midrst_href_before", 32'(href), 1);
    chk("midrst_pixel_before", 32'(pixel_out), 32'h07FF);
    chk("midrst_count_before", 32'(frame_count), 3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_href", 32'(href), 0);
    chk("midrst_vsync", 32'(vsync), 0);
    chk("midrst_pixel", 32'(pixel_out), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_frame_done", 32'(frame_done), 0);
    chk("midrst_count", 32'(frame_count), 0);

    // Moving bar over five frames; xpos restarts from 0 after the reset.
    rst         = 1'b0;
    pattern_sel = 2'b11;
    enable      = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 5; f++) begin
      int xp;
      xp = (f % 4) * 4;
      run_frame(2'b11, xp, f + 1, 2'b11, f == 4);
      chk("move_left", 32'(row0_px[xp]), 32'hFFFF);
      chk("move_right", 32'(row0_px[xp + 3]), 32'hFFFF);
      chk("move_after", 32'(row0_px[(xp + 4) % 16]), 32'h0000);
    end
    @(negedge clk);
    chk("final_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
